// File: rtl/cla_pkg.sv
// cla_pkg: shared widths for the pipelined carry-lookahead adder
package cla_pkg;
  localparam int CLA_WIDTH = 16;
  localparam int CLA_GROUP = 4;
  localparam int NGROUPS = CLA_WIDTH / CLA_GROUP;
endpackage

// File: rtl/cla_cell.sv
// cla_cell: single-bit lookahead carry cell, c_out = g | (p & c_in)
module cla_cell (
  input  logic p,
  input  logic g,
  input  logic c_in,
  output logic c_out
);
  assign c_out = g | (p & c_in);
endmodule

// File: rtl/cla_group.sv
// cla_group: GROUP-bit lookahead block built from carry cells
module cla_group import cla_pkg::*; #(
  parameter int GROUP = CLA_GROUP
) (
  input  logic [GROUP-1:0] p,
  input  logic [GROUP-1:0] g,
  input  logic             c_in,
  output logic [GROUP-1:0] c,
  output logic             gp,
  output logic             gg,
  output logic             c_out
);
  assign c[0] = c_in;
  for (genvar i = 0; i < GROUP - 1; i++) begin : g_bit
    cla_cell u_cell (.p(p[i]), .g(g[i]), .c_in(c[i]), .c_out(c[i+1]));
  end
  // group propagate is the AND of all bits; group generate folds g/p from LSB up
  always_comb begin
    gp = &p;
    gg = 1'b0;
    for (int i = 0; i < GROUP; i++) gg = g[i] | (p[i] & gg);
  end
  cla_cell u_grp_cell (.p(gp), .g(gg), .c_in(c_in), .c_out(c_out));
endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: two-stage pipelined carry-lookahead adder with valid/ready handshake
module cla_pipe_adder import cla_pkg::*; #(
  parameter int WIDTH = CLA_WIDTH,
  parameter int GROUP = CLA_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NG = WIDTH / GROUP;
  logic [WIDTH-1:0] p_q, p_d, g_q, g_d, sum_q, sum_d, c_bit;
  logic             cin_q, cin_d, s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;
  logic [NG:0]      grp_c;
  logic [NG-1:0]    grp_p, grp_g;
  logic             adv1, adv2, take_in, ld2, blk_p, blk_g;
  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;
  assign take_in  = adv1 && in_valid;
  assign ld2      = adv2 && s1_valid_q;
  assign grp_c[0] = cin_q;
  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla_group #(.GROUP(GROUP)) u_grp (
      .p    (p_q[k*GROUP +: GROUP]),
      .g    (g_q[k*GROUP +: GROUP]),
      .c_in (grp_c[k]),
      .c    (c_bit[k*GROUP +: GROUP]),
      .gp   (grp_p[k]),
      .gg   (grp_g[k]),
      .c_out(grp_c[k+1])
    );
  end
  // stage 1: capture propagate/generate and carry-in on an input transfer
  always_comb begin
    s1_valid_d = adv1 ? in_valid : s1_valid_q;
    p_d        = take_in ? a ^ b : p_q;
    g_d        = take_in ? a & b : g_q;
    cin_d      = take_in ? cin : cin_q;
  end
  // stage 2: block-level lookahead for carry-out, group chain for sum and overflow
  always_comb begin
    blk_p = 1'b1;
    blk_g = 1'b0;
    for (int k = 0; k < NG; k++) begin
      blk_g = grp_g[k] | (grp_p[k] & blk_g);
      blk_p = blk_p & grp_p[k];
    end
    s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
    sum_d      = ld2 ? p_q ^ c_bit : sum_q;
    cout_d     = ld2 ? blk_g | (blk_p & cin_q) : cout_q;
    ovf_d      = ld2 ? grp_c[NG] ^ c_bit[WIDTH-1] : ovf_q;
  end
  // pipeline registers, cleared immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q        <= '0;
      g_q        <= '0;
      cin_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      p_q        <= p_d;
      g_q        <= g_d;
      cin_q      <= cin_d;
      s1_valid_q <= s1_valid_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      s2_valid_q <= s2_valid_d;
    end
  end
  assign out_valid = s2_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: scoreboard bench for the pipelined CLA adder
module tb_cla_pipe_adder;
  logic        clk = 1'b0, rst = 1'b0, in_valid = 1'b0, in_ready, cin = 1'b0;
  logic        out_valid, out_ready = 1'b0, cout, ovf;
  logic [15:0] a = '0, b = '0, sum;
  int          n_cmp = 0, n_err = 0, n_pop = 0;
  logic [17:0] q[$];
  logic [17:0] last = '0;
  logic [15:0] bpa[4] = '{16'h1234, 16'hFFFF, 16'h8001, 16'h0F0F};
  logic [15:0] bpb[4] = '{16'h4321, 16'h0001, 16'h8001, 16'hF0F1};

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] s;
    s = {1'b0, x} + {1'b0, y} + {16'b0, c};
    return {(x[15] == y[15]) && (s[15] != x[15]), s};
  endfunction

  task automatic step(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                      input logic ic, input logic ordy, output logic acc);
    logic [17:0] e;
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; cin = ic; out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
      else begin
        e = q.pop_front();
        last = {ovf, cout, sum};
        n_pop++;
        chk("sum", 32'(sum), 32'(e[15:0]));
        chk("cout", 32'(cout), 32'(e[16]));
        chk("ovf", 32'(ovf), 32'(e[17]));
      end
    end
    acc = iv && in_ready;
    if (acc) q.push_back(model(ia, ib, ic));
  endtask

  task automatic drain(input int lim);
    logic acc;
    for (int i = 0; i < lim && q.size() > 0; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic op_direct(input string tag, input logic [15:0] x, input logic [15:0] y,
                           input logic c, input logic [17:0] exp);
    logic acc;
    step(1'b1, x, y, c, 1'b1, acc);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
    chk(tag, 32'(last), 32'(exp));
  endtask

  initial begin
    logic acc;
    int sent, cyc, pop0;
    #1 rst = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst = 1'b0;

    step(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b1, acc);
    chk("t2_acc", 32'(acc), 32'd1);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
    chk("lat_cycle1", 32'(out_valid), 32'd0);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
    chk("lat_cycle2", 32'(out_valid), 32'd1);
    chk("t2_result", 32'(last), 32'h00003);
    op_direct("t3_carry_chain", 16'hFFFF, 16'h0000, 1'b1, 18'h10000);
    op_direct("t4_ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 18'h28000);
    op_direct("t4_ovf_neg", 16'h8000, 16'h8000, 1'b0, 18'h30000);

    pop0 = n_pop;
    sent = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, bpa[sent], bpb[sent], 1'b0, 1'b0, acc);
      if (acc) sent++;
      if (i >= 2) begin
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_sum", 32'(sum), 32'(q[0][15:0]));
      end
    end
    chk("bp_accepts", 32'(sent), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, bpa[sent], bpb[sent], 1'b0, 1'b1, acc);
    chk("bp_passthru", 32'(acc), 32'd1);
    if (acc) sent++;
    for (int i = 0; i < 10 && sent < 4; i++) begin
      step(1'b1, bpa[sent], bpb[sent], 1'b0, 1'b1, acc);
      if (acc) sent++;
    end
    drain(10);
    chk("bp_pop_count", 32'(n_pop - pop0), 32'd4);

    step(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, acc);
    step(1'b1, 16'h3333, 16'h4444, 1'b1, 1'b0, acc);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);

    pop0 = n_pop;
    sent = 0;
    cyc = 0;
    while (sent < 10000 && cyc < 60000) begin
      step($urandom_range(3) != 0, 16'($urandom), 16'($urandom), 1'($urandom),
           $urandom_range(3) != 0, acc);
      if (acc) sent++;
      cyc++;
    end
    chk("rand_sent", 32'(sent), 32'd10000);
    drain(20);
    chk("rand_pop_count", 32'(n_pop - pop0), 32'(sent));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
